// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload widths, Op encoding and packed
// payload structs so every stage packs and unpacks its buffer fields identically.
package pipe_pkg;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 146;
  localparam int EXMEM_W = 72;
  localparam int MEMWB_W = 40;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ALU    = 3'd1,
    OP_ALUI   = 3'd2,
    OP_LOAD   = 3'd3,
    OP_STORE  = 3'd4,
    OP_BRANCH = 3'd5,
    OP_JAL    = 3'd6,
    OP_JALR   = 3'd7
  } op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    op_e         op;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    op_e         op;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    op_e         op;
  } memwb_t;

  // Stores and branches never write the register file; everything else except NOP does.
  function automatic logic op_writes_rd(input op_e op);
    return !(op inside {OP_NOP, OP_STORE, OP_BRANCH});
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Parametrised saturating up-counter with increment enable and asynchronous
// active-low clear; holds at all-ones once reached.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage register with stall, flush and bubble.
// Define PIPE_STAGE_BUF_SKID_EN for a two-entry (main + skid) variant with registered ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = IDEX_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  input  logic                 flush_i,
  input  logic                 bubble_i,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic                 main_valid_q;
  logic                 main_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q;
  logic [PAYLOAD_W-1:0] main_data_d;
  logic                 accept;
  logic                 xfer;
  logic                 main_free;

  assign accept    = in_valid_i & in_ready_o;
  assign xfer      = main_valid_q & out_ready_i;
  assign main_free = ~main_valid_q | out_ready_i;

`ifdef PIPE_STAGE_BUF_SKID_EN

  logic                 skid_valid_q;
  logic                 skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q;
  logic [PAYLOAD_W-1:0] skid_data_d;

  // Ready comes only from flops, so out_ready_i never reaches upstream combinationally.
  assign in_ready_o = ~skid_valid_q & ~bubble_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (main_free) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_free) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end
    // Flush kills valids only; data registers keep whatever was loaded.
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`else

  assign in_ready_o = ~bubble_i & main_free;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data_i;
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end
    if (flush_i) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
    end
  end

`endif

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (main_valid_q & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule
